// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings, requester ids and default sizes
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
  localparam int DEPTH_DEF = 32;
  localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with bounded lock bursts
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic       gnt_valid,
  output logic       gnt_id
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic          last_gnt;
  logic          lock_valid;
  logic          lock_owner;
  logic [CW-1:0] burst_cnt;
  logic          lock_hold;
  logic [1:0]    elig;
  // a live lock with burst budget left narrows eligibility to its owner
  always_comb begin
    lock_hold = lock_valid && (burst_cnt < CW'(MAX_BURST)) && req[lock_owner];
    elig      = lock_hold ? (2'b01 << lock_owner) : req;
    gnt_valid = |elig;
    gnt_id    = &elig ? ~last_gnt : elig[1];
  end
  // grant history and lock bookkeeping, updated when a grant is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= REQ_DBG;
      lock_valid <= 1'b0;
      lock_owner <= REQ_CPU;
      burst_cnt  <= '0;
    end else if (idle && gnt_valid) begin
      last_gnt   <= gnt_id;
      lock_valid <= lock[gnt_id];
      lock_owner <= gnt_id;
      burst_cnt  <= lock[gnt_id] ? (lock_hold ? burst_cnt + 1'b1 : CW'(1)) : '0;
    end else if (idle && lock_valid && !lock_hold) begin
      lock_valid <= 1'b0;
      burst_cnt  <= '0;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between CPU and debug scanner
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          lock,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [63:0]         wdata,
  output logic [1:0]          ack,
  output logic [1:0]          err,
  output logic [31:0]         rdata,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_writeData,
  output logic                mem_memWrite,
  output logic                mem_memRead,
  input  logic [31:0]         mem_readData
);
  state_t            state;
  logic              gnt_id;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [31:0]       lat_wdata;
  logic              arb_valid;
  logic              arb_gnt;
  logic              in_range;
  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk      (clock_in),
    .rst      (reset),
    .idle     (state == IDLE),
    .req      (req),
    .lock     (lock),
    .gnt_valid(arb_valid),
    .gnt_id   (arb_gnt)
  );
  // memory strobes fire only in ACCESS and only for legal word addresses
  always_comb begin
    in_range      = lat_addr < ADDR_W'(DEPTH);
    mem_address   = 32'(lat_addr);
    mem_writeData = lat_wdata;
    mem_memWrite  = (state == ACCESS) && lat_we && in_range;
    mem_memRead   = (state == ACCESS) && !lat_we && in_range;
  end
  // IDLE latches the winner, ACCESS captures read data, RESP presents the ack
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= IDLE;
      gnt_id    <= REQ_CPU;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      ack       <= '0;
      err       <= '0;
      rdata     <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      unique case (state)
        IDLE: if (arb_valid) begin
          state     <= ACCESS;
          gnt_id    <= arb_gnt;
          lat_addr  <= arb_gnt ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          lat_we    <= we[arb_gnt];
          lat_wdata <= arb_gnt ? wdata[63:32] : wdata[31:0];
        end
        ACCESS: begin
          state <= RESP;
          rdata <= (in_range && !lat_we) ? mem_readData : '0;
          ack   <= 2'b01 << gnt_id;
          err   <= {2{~in_range}} & (2'b01 << gnt_id);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, memory drive and responses
module tb_dmem_arbiter;
  logic        clock_in = 1'b0;
  logic        reset;
  logic [1:0]  req, we, lock, ack, err;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead;
  logic [31:0] mem [0:31];
  int checks = 0;
  int errors = 0;
  int c, w, r;

  dmem_arbiter dut (
    .clock_in(clock_in), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData)
  );

  always #5 clock_in = ~clock_in;

  assign mem_readData = mem[mem_address[4:0]];

  always @(negedge clock_in) if (mem_memWrite) mem[mem_address[4:0]] <= mem_writeData;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_ack(output int cyc, output int wr, output int rd);
    cyc = 0; wr = 0; rd = 0;
    while (cyc < 12) begin
      @(posedge clock_in); #1;
      cyc++;
      wr += int'(mem_memWrite);
      rd += int'(mem_memRead);
      if (ack != 2'b00) break;
    end
  endtask

  task automatic to_idle();
    req = 2'b00; lock = 2'b00;
    @(posedge clock_in); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i;
    reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clock_in);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_writeData, 0);
    check("rst_wr", 32'(mem_memWrite), 0);
    check("rst_rd", 32'(mem_memRead), 0);
    reset = 1'b0;
    req = 2'b01; we = 2'b00; addr = {32'd0, 32'd5};
    step_ack(c, w, r);
    check("rd5_ack", 32'(ack), 1);
    check("rd5_err", 32'(err), 0);
    check("rd5_rdata", rdata, 5);
    check("rd5_lat", c, 2);
    check("rd5_rdpulse", r, 1);
    check("rd5_wrpulse", w, 0);
    to_idle();
    req = 2'b01; we = 2'b01; addr = {32'd0, 32'd3}; wdata = {32'd0, 32'hDEADBEEF};
    step_ack(c, w, r);
    check("wr3_ack", 32'(ack), 1);
    check("wr3_wrpulse", w, 1);
    check("wr3_rdpulse", r, 0);
    check("wr3_rdata", rdata, 0);
    check("wr3_mem", mem[3], 32'hDEADBEEF);
    to_idle();
    req = 2'b01; we = 2'b00;
    step_ack(c, w, r);
    check("rd3_ack", 32'(ack), 1);
    check("rd3_rdata", rdata, 32'hDEADBEEF);
    to_idle();
    req = 2'b10; we = 2'b10; addr = {32'd40, 32'd0}; wdata = {32'h12345678, 32'd0};
    step_ack(c, w, r);
    check("oor_ack", 32'(ack), 2);
    check("oor_err", 32'(err), 2);
    check("oor_rdata", rdata, 0);
    check("oor_wrpulse", w, 0);
    check("oor_mem8", mem[8], 8);
    to_idle();
    req = 2'b11; we = 2'b00; addr = {32'd3, 32'd5};
    for (int i = 0; i < 4; i++) begin
      step_ack(c, w, r);
      check($sformatf("rr_ack%0d", i), 32'(ack), (i % 2 == 0) ? 1 : 2);
      check($sformatf("rr_rdata%0d", i), rdata, (i % 2 == 0) ? 32'd5 : 32'hDEADBEEF);
      check($sformatf("rr_lat%0d", i), c, (i == 0) ? 2 : 3);
    end
    to_idle();
    req = 2'b11; we = 2'b00; lock = 2'b01; addr = {32'd2, 32'd1};
    for (int i = 0; i < 6; i++) begin
      step_ack(c, w, r);
      check($sformatf("lk_ack%0d", i), 32'(ack), (i == 4) ? 2 : 1);
      check($sformatf("lk_rdata%0d", i), rdata, (i == 4) ? 2 : 1);
      check($sformatf("lk_lat%0d", i), c, (i == 0) ? 2 : 3);
    end
    to_idle();
    req = 2'b01; we = 2'b01; addr = {32'd0, 32'd7}; wdata = {32'd0, 32'hCAFEF00D}; reset = 1'b1;
    @(posedge clock_in); #1;
    check("rg_wr", 32'(mem_memWrite), 0);
    check("rg_ack", 32'(ack), 0);
    check("rg_addr", mem_address, 0);
    check("rg_mem7", mem[7], 7);
    reset = 1'b0;
    step_ack(c, w, r);
    check("rg_next_ack", 32'(ack), 1);
    check("rg_next_lat", c, 2);
    check("rg_next_wr", w, 1);
    check("rg_next_mem7", mem[7], 32'hCAFEF00D);
    to_idle();
    check("end_ack", 32'(ack), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
